// File: rtl/fp_pkg.sv
// Shared floating-point definitions: class-flag bit positions and the
// single-precision field widths used as parameter defaults.
package fp_pkg;

    localparam int CLS_ZERO   = 0;
    localparam int CLS_DENORM = 1;
    localparam int CLS_INF    = 2;
    localparam int CLS_QNAN   = 3;
    localparam int CLS_SNAN   = 4;
    localparam int CLS_W      = 5;

    localparam int SP_EXP_W   = 8;
    localparam int SP_FRAC_W  = 23;

endpackage

// File: rtl/fp_unpack_lane.sv
// Combinational decoder for one packed IEEE-754 operand: sign, effective
// exponent, mantissa with hidden bit, and one-hot class flags.
module fp_unpack_lane
    import fp_pkg::*;
#(
    parameter int EXP_W  = SP_EXP_W,
    parameter int FRAC_W = SP_FRAC_W
) (
    input  logic [EXP_W+FRAC_W:0] op_i,
    output logic                  sign_o,
    output logic [EXP_W-1:0]      exp_o,
    output logic [FRAC_W:0]       man_o,
    output logic [CLS_W-1:0]      cls_o
);

    logic [EXP_W-1:0]  expField;
    logic [FRAC_W-1:0] fracField;

    assign sign_o    = op_i[EXP_W+FRAC_W];
    assign expField  = op_i[FRAC_W +: EXP_W];
    assign fracField = op_i[FRAC_W-1:0];

    // Denormals report an effective exponent of 1 so downstream alignment
    // can treat them like normals with a zero hidden bit.
    always_comb begin
        exp_o = expField;
        man_o = {1'b1, fracField};
        cls_o = '0;
        if (expField == '0) begin
            man_o = {1'b0, fracField};
            if (fracField == '0) begin
                cls_o[CLS_ZERO] = 1'b1;
                exp_o           = '0;
            end else begin
                cls_o[CLS_DENORM] = 1'b1;
                exp_o             = EXP_W'(1);
            end
        end else if (&expField) begin
            if (fracField == '0) begin
                cls_o[CLS_INF] = 1'b1;
            end else if (fracField[FRAC_W-1]) begin
                cls_o[CLS_QNAN] = 1'b1;
            end else begin
                cls_o[CLS_SNAN] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage elastic unpacker: S1 registers raw operands, S2 registers the
// decoded fields of every operand. Full throughput when out_ready is held.
module fp_unpack_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = SP_EXP_W,
    parameter int FRAC_W = SP_FRAC_W,
    parameter int NOPS   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NOPS*(1+EXP_W+FRAC_W)-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NOPS-1:0]              out_sign,
    output logic [NOPS*EXP_W-1:0]        out_exp,
    output logic [NOPS*(FRAC_W+1)-1:0]   out_man,
    output logic [NOPS*CLS_W-1:0]        out_cls,
    output logic [1:0]                   occupancy
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 1;

    logic                    rdyEn_q;
    logic                    s1Valid_q;
    logic [NOPS*W-1:0]       s1Data_q;
    logic                    s2Valid_q;
    logic [NOPS-1:0]         s2Sign_q;
    logic [NOPS*EXP_W-1:0]   s2Exp_q;
    logic [NOPS*MW-1:0]      s2Man_q;
    logic [NOPS*CLS_W-1:0]   s2Cls_q;

    logic [NOPS-1:0]         decSign_d;
    logic [NOPS*EXP_W-1:0]   decExp_d;
    logic [NOPS*MW-1:0]      decMan_d;
    logic [NOPS*CLS_W-1:0]   decCls_d;
    logic                    s1Advance;

    // rdyEn_q keeps in_ready low throughout reset and until the first edge after release.
    assign s1Advance = !s2Valid_q || out_ready;
    assign in_ready  = rdyEn_q && (!s1Valid_q || s1Advance);

    for (genvar i = 0; i < NOPS; i++) begin : gLane
        fp_unpack_lane #(
            .EXP_W  (EXP_W),
            .FRAC_W (FRAC_W)
        ) uLane (
            .op_i   (s1Data_q[i*W +: W]),
            .sign_o (decSign_d[i]),
            .exp_o  (decExp_d[i*EXP_W +: EXP_W]),
            .man_o  (decMan_d[i*MW +: MW]),
            .cls_o  (decCls_d[i*CLS_W +: CLS_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdyEn_q   <= 1'b0;
            s1Valid_q <= 1'b0;
            s1Data_q  <= '0;
            s2Valid_q <= 1'b0;
            s2Sign_q  <= '0;
            s2Exp_q   <= '0;
            s2Man_q   <= '0;
            s2Cls_q   <= '0;
        end else begin
            rdyEn_q <= 1'b1;
            if (in_ready) begin
                s1Valid_q <= in_valid;
            end
            if (in_ready && in_valid) begin
                s1Data_q <= in_data;
            end
            if (s1Advance) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Sign_q <= decSign_d;
                    s2Exp_q  <= decExp_d;
                    s2Man_q  <= decMan_d;
                    s2Cls_q  <= decCls_d;
                end
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign out_sign  = s2Sign_q;
    assign out_exp   = s2Exp_q;
    assign out_man   = s2Man_q;
    assign out_cls   = s2Cls_q;
    assign occupancy = {1'b0, s1Valid_q} + {1'b0, s2Valid_q};

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Bench for fp_unpack_pipe: directed vectors with literal expectations plus a
// queue-based reference decoder checked against the outputs every cycle.
module tb_fp_unpack_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sign;
    logic [15:0] out_exp;
    logic [47:0] out_man;
    logic [9:0]  out_cls;
    logic [1:0]  occupancy;

    logic         inValid2;
    logic         inReady2;
    logic [255:0] inData2;
    logic         outValid2;
    logic [3:0]   outSign2;
    logic [43:0]  outExp2;
    logic [211:0] outMan2;
    logic [19:0]  outCls2;
    logic [1:0]   occ2;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [63:0] modelQ[$];
    int          emitCycles[$];
    int          cycleNo = 0;
    logic        sawEdge = 1'b0;
    logic        willAccept = 1'b0;
    logic        willEmit = 1'b0;
    logic [63:0] acceptData = '0;
    logic        holdPending = 1'b0;
    logic [1:0]  heldSign;
    logic [15:0] heldExp;
    logic [47:0] heldMan;
    logic [9:0]  heldCls;

    fp_unpack_pipe #(.EXP_W(8), .FRAC_W(23), .NOPS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
        .out_cls(out_cls), .occupancy(occupancy)
    );

    fp_unpack_pipe #(.EXP_W(11), .FRAC_W(52), .NOPS(4)) dutDouble (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2),
        .out_valid(outValid2), .out_ready(1'b1),
        .out_sign(outSign2), .out_exp(outExp2), .out_man(outMan2),
        .out_cls(outCls2), .occupancy(occ2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder written from the IEEE-754 field rules with integer arithmetic.
    function automatic void modelDecode(input logic [63:0] w, output logic [1:0] s,
                                        output logic [15:0] e, output logic [47:0] m,
                                        output logic [9:0] c);
        s = '0; e = '0; m = '0; c = '0;
        for (int i = 0; i < 2; i++) begin
            int unsigned opw, ex, fr, ee, mm, cc;
            opw = 32'(w >> (i * 32));
            ex  = (opw >> 23) & 32'hFF;
            fr  = opw & 32'h7FFFFF;
            if (ex == 0 && fr == 0) begin
                ee = 0; mm = fr; cc = 1;
            end else if (ex == 0) begin
                ee = 1; mm = fr; cc = 2;
            end else if (ex == 255) begin
                ee = ex; mm = fr + (1 << 23);
                cc = (fr == 0) ? 4 : ((fr >= (1 << 22)) ? 8 : 16);
            end else begin
                ee = ex; mm = fr + (1 << 23); cc = 0;
            end
            s[i]          = opw[31];
            e[i*8 +: 8]   = ee[7:0];
            m[i*24 +: 24] = mm[23:0];
            c[i*5 +: 5]   = cc[4:0];
        end
    endfunction

    always @(negedge clk) begin : compareProc
        logic [1:0]  es;
        logic [15:0] ee;
        logic [47:0] em;
        logic [9:0]  ec;
        if (!rst_n) begin
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_occupancy", occupancy, 0);
            checkOutput("rst_out_sign", out_sign, 0);
            checkOutput("rst_out_exp", out_exp, 0);
            checkOutput("rst_out_man", out_man, 0);
            checkOutput("rst_out_cls", out_cls, 0);
            willAccept  = 1'b0;
            willEmit    = 1'b0;
            holdPending = 1'b0;
        end else begin
            checkOutput("occupancy", occupancy, modelQ.size());
            if (sawEdge) begin
                checkOutput("in_ready", in_ready, (modelQ.size() < 2) || out_ready);
            end
            if (holdPending) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_sign", out_sign, heldSign);
                checkOutput("hold_exp", out_exp, heldExp);
                checkOutput("hold_man", out_man, heldMan);
                checkOutput("hold_cls", out_cls, heldCls);
            end
            if (out_valid) begin
                if (modelQ.size() == 0) begin
                    checkOutput("spurious_out_valid", out_valid, 0);
                end else begin
                    modelDecode(modelQ[0], es, ee, em, ec);
                    checkOutput("model_sign", out_sign, es);
                    checkOutput("model_exp", out_exp, ee);
                    checkOutput("model_man", out_man, em);
                    checkOutput("model_cls", out_cls, ec);
                end
            end
            willAccept  = in_valid && in_ready;
            acceptData  = in_data;
            willEmit    = out_valid && out_ready;
            holdPending = out_valid && !out_ready;
            heldSign    = out_sign;
            heldExp     = out_exp;
            heldMan     = out_man;
            heldCls     = out_cls;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            sawEdge    = 1'b0;
            willAccept = 1'b0;
            willEmit   = 1'b0;
        end else begin
            cycleNo++;
            sawEdge = 1'b1;
            if (willAccept) modelQ.push_back(acceptData);
            if (willEmit) begin
                void'(modelQ.pop_front());
                emitCycles.push_back(cycleNo);
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] w);
        logic acc;
        int   tries;
        acc      = 1'b0;
        tries    = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", acc, 1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (modelQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_timeout", modelQ.size(), 0);
    endtask

    task automatic checkLiteral(input string tag, input logic [1:0] s, input logic [15:0] e,
                                input logic [47:0] m, input logic [9:0] c);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_sign"}, out_sign, s);
        checkOutput({tag, "_exp"}, out_exp, e);
        checkOutput({tag, "_man"}, out_man, m);
        checkOutput({tag, "_cls"}, out_cls, c);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inValid2  = 1'b0;
        inData2   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] normal operands");
        applyStimulus({32'hC0000000, 32'h3F800000});
        @(posedge clk); #1;
        checkLiteral("t1", 2'b10, 16'h807F, 48'h800000_800000, 10'h000);

        $display("[TB] denormal and signed zero");
        applyStimulus({32'h80000000, 32'h00000001});
        @(posedge clk); #1;
        checkLiteral("t2", 2'b10, 16'h0001, 48'h000000_000001, 10'h022);

        $display("[TB] infinity, quiet NaN, signalling NaN");
        applyStimulus({32'h7FC00001, 32'h7F800000});
        @(posedge clk); #1;
        checkLiteral("t3a", 2'b00, 16'hFFFF, 48'hC00001_800000, 10'h104);
        applyStimulus({32'h3F800000, 32'h7F800001});
        @(posedge clk); #1;
        checkLiteral("t3b", 2'b00, 16'h7FFF, 48'h800000_800001, 10'h010);
        waitDrain();

        $display("[TB] back-to-back stream");
        emitCycles.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus({32'h41000000 | 32'(i), 32'h80000000 | 32'(i * 3)});
        end
        waitDrain();
        checkOutput("stream_count", emitCycles.size(), 8);
        if (emitCycles.size() == 8) begin
            checkOutput("stream_span", emitCycles[7] - emitCycles[0], 7);
        end

        $display("[TB] stream with backpressure");
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus({32'hFF800000 ^ 32'(i << 20), 32'h00400000 + 32'(i)});
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                checkOutput("stall_occupancy", occupancy, 2);
                checkOutput("stall_in_ready", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] double precision, four operands");
        inValid2 = 1'b1;
        inData2  = {4{64'h3FF0000000000000}};
        @(posedge clk); #1;
        inValid2 = 1'b0;
        @(posedge clk); #1;
        checkOutput("dp_valid", outValid2, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("dp_exp%0d", i), outExp2[i*11 +: 11], 11'h3FF);
            checkOutput($sformatf("dp_man%0d", i), outMan2[i*53 +: 53], 53'h10000000000000);
        end
        checkOutput("dp_cls", outCls2, 0);
        checkOutput("dp_sign", outSign2, 0);
        @(posedge clk); #1;

        $display("[TB] asynchronous reset mid-flight");
        out_ready = 1'b0;
        applyStimulus({32'h3F800000, 32'h40400000});
        applyStimulus({32'h40800000, 32'h40A00000});
        checkOutput("pre_rst_occupancy", occupancy, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_occupancy", occupancy, 0);
        checkOutput("async_rst_in_ready", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("post_rst_out_valid", out_valid, 0);
        checkOutput("post_rst_occupancy", occupancy, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
